// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if -- operand/result bundle for the sequential ALU.
//
// Handshake: a bundle moves on a rising clk edge where valid and ready are
// both 1. The producer holds valid and payload stable until that edge; ready
// may depend combinationally on the consumer's state. The input side uses
// in_valid/in_ready, the result side out_valid/out_ready; result, zero and
// cond are meaningful only while out_valid=1.
//
// Signals:
//   in_valid   producer -> alu   operand/control bundle present
//   in_ready   alu -> producer   bundle is accepted this cycle
//   alu_ctrl   producer -> alu   operation select (0..9, 10..15 undefined)
//   invert     producer -> alu   invert branch condition
//   op_a/op_b  producer -> alu   operands (op_b[4:0] = shift amount)
//   out_valid  alu -> consumer   result bundle valid
//   out_ready  consumer -> alu   result taken this cycle
//   result     alu -> consumer   operation result
//   zero       alu -> consumer   result == 0
//   cond       alu -> consumer   branch condition
//   busy       alu -> consumer   multi-cycle shift in progress
// Modports: master = producer/consumer side, slave = the ALU.
// ---------------------------------------------------------------------------
interface seq_alu_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic        invert;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cond;
  logic        busy;

  modport master (
    output in_valid, alu_ctrl, invert, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, cond, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, invert, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, cond, busy
  );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- sequential 32-bit ALU with branch-condition output.
//
// Non-shift operations complete one cycle after acceptance. Shifts (SLL, SRL,
// SRA) move one bit per cycle in the SHIFT state, so a shift by k takes k+1
// cycles; k=0 completes like a non-shift op with result=op_a. The result is
// held in DONE until the consumer takes it; a new bundle may be accepted in
// the same cycle the old result retires.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        seq_alu_if.slave (operand/result handshake, see interface)
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// ---------------------------------------------------------------------------
module seq_alu (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  state_t      state;
  logic [3:0]  ctrl_q;
  logic        invert_q;
  logic [31:0] shreg;
  logic [4:0]  cnt;

  logic        out_valid_q;
  logic        busy_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        cond_q;

  logic        accept;
  logic        in_is_shift;
  logic [4:0]  in_amt;
  logic [31:0] alu_res;
  logic [31:0] shift_next;

  // Branch condition: SUB tests equality (BEQ), every other op tests for a
  // non-zero result (BLT/BLTU via SLT/SLTU); invert turns them into the
  // complementary branches.
  function automatic logic branch_cond(input logic [3:0]  ctrl,
                                       input logic        inv,
                                       input logic [31:0] res);
    logic c;
    c = (ctrl == OP_SUB) ? (res == 32'd0) : (res != 32'd0);
    return c ^ inv;
  endfunction

  assign bus.in_ready = !rst &&
                        ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign in_amt      = bus.op_b[4:0];
  assign in_is_shift = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                       (bus.alu_ctrl == OP_SRA);

  // Single-cycle result. Shift ops only take this path when the amount is
  // zero, where the result is simply op_a.
  always_comb begin
    alu_res = 32'd0;
    case (bus.alu_ctrl)
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_ADD:  alu_res = bus.op_a + bus.op_b;
      OP_SUB:  alu_res = bus.op_a - bus.op_b;
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_SLT:  alu_res = {31'd0, ($signed(bus.op_a) < $signed(bus.op_b))};
      OP_SLTU: alu_res = {31'd0, (bus.op_a < bus.op_b)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res = bus.op_a;
      default: alu_res = 32'd0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    shift_next = {1'b0, shreg[31:1]};
    case (ctrl_q)
      OP_SLL:  shift_next = {shreg[30:0], 1'b0};
      OP_SRA:  shift_next = {shreg[31], shreg[31:1]};
      default: shift_next = {1'b0, shreg[31:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ctrl_q      <= 4'd0;
      invert_q    <= 1'b0;
      shreg       <= 32'd0;
      cnt         <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= 32'd0;
      zero_q      <= 1'b1;
      cond_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ctrl_q   <= bus.alu_ctrl;
            invert_q <= bus.invert;
            shreg    <= bus.op_a;
            cnt      <= in_amt;
            if (in_is_shift && (in_amt != 5'd0)) begin
              state       <= SHIFT;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              // Covers a DONE->DONE back-to-back: the old result retires on
              // this edge and the new one replaces it with no idle bubble.
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == 32'd0);
              cond_q      <= branch_cond(bus.alu_ctrl, bus.invert, alu_res);
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end

        SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - 5'd1;
          // cnt==1 means this edge performs the last bit step.
          if (cnt == 5'd1) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            result_q    <= shift_next;
            zero_q      <= (shift_next == 32'd0);
            cond_q      <= branch_cond(ctrl_q, invert_q, shift_next);
          end
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.cond      = cond_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed self-checking bench for seq_alu.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  seq_alu_if bus ();

  seq_alu dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [3:0] ctrl, input logic inv,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = ctrl;
    bus.invert   = inv;
    bus.op_a     = a;
    bus.op_b     = b;
    exp_q.push_back(exp_res);
  endtask

  // Called at a falling edge with out_ready=1 and the DUT able to accept.
  task automatic run_op(input string tag, input logic [3:0] ctrl,
                        input logic inv, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_cond, input int exp_lat,
                        input int exp_busy);
    int          lat;
    int          busy_cycles;
    logic [31:0] exp;
    lat         = 1;
    busy_cycles = 0;
    check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    drive_op(ctrl, inv, a, b, exp_res);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_cycles, exp_busy);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check({tag, " result"}, bus.result, exp);
    check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, (exp == 32'd0)});
    check({tag, " cond"}, {31'd0, bus.cond}, {31'd0, exp_cond});
    @(negedge clk);
    check({tag, " retire"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ov_seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'd0;
    bus.invert    = 1'b0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst busy",      {31'd0, bus.busy},      32'd0);
    check("rst result",    bus.result,             32'd0);
    check("rst zero",      {31'd0, bus.zero},      32'd1);
    check("rst cond",      {31'd0, bus.cond},      32'd0);
    check("rst state",     {30'd0, dbg_state},     32'd0);
    rst = 1'b0;
    #1;
    check("post_rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // tag ctrl inv a b expected cond latency busy
    run_op("add_wrap",  4'd2,  1'b1, 32'hFFFF_FFFF, 32'd1,  32'd0,          1'b1, 1, 0);
    run_op("sra_neg",   4'd9,  1'b0, 32'h8000_0000, 32'd4,  32'hF800_0000,  1'b1, 5, 4);
    run_op("bne_eq",    4'd3,  1'b1, 32'd5,         32'd5,  32'd0,          1'b0, 1, 0);
    run_op("blt_slt",   4'd6,  1'b0, 32'hFFFF_FFFF, 32'd1,  32'd1,          1'b1, 1, 0);
    run_op("sltu",      4'd7,  1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,          1'b0, 1, 0);
    run_op("srl",       4'd8,  1'b0, 32'h8000_0000, 32'd3,  32'h1000_0000,  1'b1, 4, 3);
    run_op("sub_wrap",  4'd3,  1'b1, 32'd0,         32'd1,  32'hFFFF_FFFF,  1'b1, 1, 0);
    run_op("sra_k31",   4'd9,  1'b0, 32'h7000_0000, 32'd31, 32'd0,          1'b0, 32, 31);
    run_op("sll_k0",    4'd5,  1'b0, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF,  1'b1, 1, 0);
    run_op("undef_12",  4'd12, 1'b0, 32'h1234_5678, 32'h9,  32'd0,          1'b0, 1, 0);
    run_op("and",       4'd0,  1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b1, 1, 0);

    // Result held while the consumer stalls, then back-to-back retire+accept.
    bus.out_ready = 1'b0;
    drive_op(4'd0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("hold first out_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold result",    bus.result,             exp_q[0]);
      check("hold in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    void'(exp_q.pop_front());
    bus.out_ready = 1'b1;
    drive_op(4'd4, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678);
    #1;
    check("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("b2b result",    bus.result,             exp_q.pop_front());
    check("b2b state",     {30'd0, dbg_state},     32'd2);
    @(negedge clk);
    check("b2b retire", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a long SLL abandons it.
    drive_op(4'd5, 1'b0, 32'd1, 32'd20, 32'h0010_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_sll busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort state",     {30'd0, dbg_state},     32'd0);
    check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort result",    bus.result,             32'd0);
    check("abort busy",      {31'd0, bus.busy},      32'd0);
    rst = 1'b0;
    void'(exp_q.pop_front());
    ov_seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    check("abort no_result", ov_seen, 0);
    run_op("or_after_rst", 4'd1, 1'b0, 32'hF0, 32'h0F, 32'hFF, 1'b1, 1, 0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
